instr_fetch_unit: RTL and testbench

- Upstream neighbour of control_unit: holds the PC, reads a synchronous instruction memory and buffers fetched words in a small queue.
- Presents {instruction, PC, opcode} to decode through a valid/ready handshake.
- Accepts branch redirects from execute, stops at a HALT opcode, and has a program-load write port usable while idle.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/fetch_queue.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types: instruction width, opcode field, halt opcode and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int IW     = 16;
  localparam int OP_LSB = 12;
  localparam int OP_W   = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  function automatic opcode_t opcode_of(input logic [IW-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake: head instruction, its PC and opcode, valid/ready.
interface instr_fetch_unit_if import cpu_pkg::*; #(
  parameter int AW = 6
);

  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  opcode_t       out_opcode;
  logic [AW-1:0] out_pc;

  modport master (
    output out_valid, out_instr, out_opcode, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_opcode, out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs; flush beats push and pop.
// Head outputs read as zero while the queue is empty.
module fetch_queue import cpu_pkg::*; #(
  parameter int AW     = 6,
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [AW-1:0]                push_pc,
  input  logic [IW-1:0]                push_instr,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output logic                         full,
  output logic                         empty,
  output logic [AW-1:0]                head_pc,
  output logic [IW-1:0]                head_instr
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [AW-1:0] pc_mem    [QDEPTH];
  logic [IW-1:0] instr_mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_pc    = empty ? '0 : pc_mem[rd_ptr];
  assign head_instr = empty ? '0 : instr_mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, synchronous instruction memory with a load port,
// credit-limited read issue into a small output queue, HALT stop and
// branch redirect.
module instr_fetch_unit import cpu_pkg::*; #(
  parameter int AW     = 6,
  parameter int QDEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                imem_we,
  input  logic [AW-1:0]       imem_waddr,
  input  logic [IW-1:0]       imem_wdata,
  input  logic                redirect,
  input  logic [AW-1:0]       redirect_pc,
  instr_fetch_unit_if.master  dec,
  output logic                halted
);

  fetch_state_t state, state_nxt;

  logic [IW-1:0] imem [2**AW];
  logic [AW-1:0] pc;
  logic          inflight;
  logic [AW-1:0] rd_pc;
  logic [IW-1:0] rd_data;

  logic [$clog2(QDEPTH+1)-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic [AW-1:0] q_head_pc;
  logic [IW-1:0] q_head_instr;

  logic redirect_act;
  logic pop;
  logic push;
  logic halt_push;
  logic credit_ok;
  logic rd_en;

  assign redirect_act = redirect && (state != IDLE);
  assign pop          = dec.out_valid && dec.out_ready;
  assign push         = inflight && !redirect_act;
  assign halt_push    = push && (opcode_of(rd_data) == HALT_OP);

  // A pop this cycle frees a slot before the new read lands, so counting it
  // keeps back-to-back issue going at one word per cycle without overflow.
  assign credit_ok = (!q_full || pop) &&
                     ((int'(q_count) + int'(inflight) - int'(pop)) < QDEPTH);

  // No issue on the cycle the HALT word lands, so nothing past it is fetched.
  assign rd_en = (state == RUN) && !redirect_act && !halt_push && credit_ok;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start, halt on HALT push, redirect resumes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (redirect_act) state_nxt = RUN;
               else if (halt_push) state_nxt = HALT;
      HALT:    if (redirect_act) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // PC advance and in-flight read tracking; redirect drops the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      inflight <= 1'b0;
    end else if (redirect_act) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      if (rd_en) pc <= pc + AW'(1);
      inflight <= rd_en;
    end
  end

  // Instruction memory: program load in IDLE, one-cycle registered read.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && imem_we) imem[imem_waddr] <= imem_wdata;
    if (rd_en) begin
      rd_data <= imem[pc];
      rd_pc   <= pc;
    end
  end

  fetch_queue #(
    .AW     (AW),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_act),
    .push_pc    (rd_pc),
    .push_instr (rd_data),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty),
    .head_pc    (q_head_pc),
    .head_instr (q_head_instr)
  );

  assign dec.out_valid  = !q_empty;
  assign dec.out_instr  = q_head_instr;
  assign dec.out_opcode = opcode_of(q_head_instr);
  assign dec.out_pc     = q_head_pc;
  assign halted         = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized ready and
// redirect traffic checked against a program-order delivery model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int AW     = 6;
  localparam int QDEPTH = 2;
  localparam int NW     = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [IW-1:0] imem_wdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halted;

  instr_fetch_unit_if #(.AW(AW)) dif();

  instr_fetch_unit #(.AW(AW), .QDEPTH(QDEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec         (dif),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] mem_m [NW];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; redirect = 1'b0;
    dif.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_random(input int halt_pct);
    for (int i = 0; i < NW; i++) begin
      mem_m[i] = IW'($urandom);
      if (int'($urandom_range(99)) < halt_pct) mem_m[i][15:12] = HALT_OP;
      else if (mem_m[i][15:12] == HALT_OP) mem_m[i][15:12] = 4'h7;
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < NW; i++) begin
      imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = mem_m[i];
      tick();
    end
    imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", dif.out_valid); end
    n_cmp++; if (dif.out_instr !== '0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", dif.out_instr); end
    n_cmp++; if (dif.out_opcode !== '0) begin n_err++; $display("FAIL rst_opcode got=%h exp=0", dif.out_opcode); end
    n_cmp++; if (dif.out_pc !== '0) begin n_err++; $display("FAIL rst_pc got=%0d exp=0", dif.out_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%b exp=0", halted); end
    fill_random(0);
    mem_m[0] = 16'h1234;
    load_prog();
    dif.out_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    n_cmp++; if (dif.out_valid !== 1'b1) begin n_err++; $display("FAIL midrun_valid got=%b exp=1", dif.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid got=%b exp=0", dif.out_valid); end
    n_cmp++; if (dif.out_instr !== '0) begin n_err++; $display("FAIL async_instr got=%h exp=0", dif.out_instr); end
    n_cmp++; if (dif.out_pc !== '0) begin n_err++; $display("FAIL async_pc got=%0d exp=0", dif.out_pc); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load_run();
    logic [IW-1:0] prog [4];
    prog[0] = 16'h1000; prog[1] = 16'h2000; prog[2] = 16'h3000; prog[3] = 16'hF000;
    do_reset();
    for (int i = 0; i < NW; i++) mem_m[i] = 16'h4000 | IW'(i);
    for (int i = 0; i < 4; i++) mem_m[i] = prog[i];
    load_prog();
    dif.out_ready = 1'b1;
    pulse_start();
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_k got=%b exp=0", dif.out_valid); end
    tick();
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_k1 got=%b exp=0", dif.out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (dif.out_valid !== 1'b1 || dif.out_pc !== AW'(i) || dif.out_opcode !== prog[i][15:12]) begin
        n_err++;
        $display("FAIL run_seq%0d got v=%b pc=%0d op=%h exp v=1 pc=%0d op=%h",
                 i, dif.out_valid, dif.out_pc, dif.out_opcode, i, prog[i][15:12]);
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got=%b exp=1", halted); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (dif.out_valid !== 1'b0) begin
        n_err++; $display("FAIL after_halt%0d got v=%b pc=%0d exp v=0", i, dif.out_valid, dif.out_pc);
      end
    end
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    for (int i = 0; i < NW; i++) mem_m[i] = 16'h1000 | IW'(i);
    load_prog();
    dif.out_ready = 1'b0;
    pulse_start();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dif.out_valid !== 1'b1 || dif.out_pc !== '0 || dif.out_instr !== 16'h1000) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b pc=%0d instr=%h exp v=1 pc=0 instr=1000",
                 i, dif.out_valid, dif.out_pc, dif.out_instr);
      end
      tick();
    end
    dif.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (dif.out_valid) begin
        n_cmp++;
        if (dif.out_pc !== AW'(got) || dif.out_instr !== mem_m[got]) begin
          n_err++;
          $display("FAIL bp_order%0d got pc=%0d instr=%h exp pc=%0d instr=%h",
                   got, dif.out_pc, dif.out_instr, got, mem_m[got]);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL bp_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_redirect();
    int got;
    do_reset();
    for (int i = 0; i < NW; i++) mem_m[i] = 16'h1000 | IW'(i);
    load_prog();
    dif.out_ready = 1'b0;
    pulse_start();
    tick(); tick(); tick();
    dif.out_ready = 1'b1;
    tick(); tick();
    dif.out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (dif.out_pc !== AW'(2) || dif.out_valid !== 1'b1) begin n_err++; $display("FAIL redir_pre got v=%b pc=%0d exp v=1 pc=2", dif.out_valid, dif.out_pc); end
    redirect = 1'b1; redirect_pc = 6'd20;
    tick();
    redirect = 1'b0;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got=%b exp=0", dif.out_valid); end
    tick();
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap got=%b exp=0", dif.out_valid); end
    tick();
    n_cmp++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 6'd20) begin n_err++; $display("FAIL redir_first got v=%b pc=%0d exp v=1 pc=20", dif.out_valid, dif.out_pc); end
    dif.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (dif.out_valid) begin
        n_cmp++;
        if (dif.out_pc !== AW'(20 + got) || dif.out_instr !== mem_m[20 + got]) begin
          n_err++; $display("FAIL redir_seq%0d got pc=%0d exp pc=%0d", got, dif.out_pc, 20 + got);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL redir_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_halt_redirect();
    int got;
    int c;
    do_reset();
    for (int i = 0; i < NW; i++) mem_m[i] = 16'h2000 | IW'(i);
    mem_m[3] = 16'hF003;
    load_prog();
    dif.out_ready = 1'b1;
    pulse_start();
    c = 0;
    while (!halted && c < 20) begin tick(); c++; end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL hr_halt got=%b exp=1", halted); end
    tick(); tick(); tick();
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL hr_drain got=%b exp=0", dif.out_valid); end
    redirect = 1'b1; redirect_pc = 6'd5;
    tick();
    redirect = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL hr_resume got=%b exp=0", halted); end
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      if (dif.out_valid) begin
        n_cmp++;
        if (dif.out_pc !== AW'(5 + got) || dif.out_instr !== mem_m[5 + got]) begin
          n_err++; $display("FAIL hr_seq%0d got pc=%0d exp pc=%0d", got, dif.out_pc, 5 + got);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL hr_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_wrap();
    int got;
    do_reset();
    fill_random(0);
    load_prog();
    pulse_start();
    got = 0;
    for (int c = 0; c < 600 && got < 68; c++) begin
      dif.out_ready = ($urandom_range(3) != 0);
      if (dif.out_valid && dif.out_ready) begin
        n_cmp++;
        if (dif.out_pc !== AW'(got % NW) || dif.out_instr !== mem_m[got % NW]) begin
          n_err++;
          $display("FAIL wrap%0d got pc=%0d instr=%h exp pc=%0d instr=%h",
                   got, dif.out_pc, dif.out_instr, got % NW, mem_m[got % NW]);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 68) begin n_err++; $display("FAIL wrap_timeout got=%0d exp=68", got); end
  endtask

  task automatic test_ignored();
    int got;
    do_reset();
    redirect = 1'b1; redirect_pc = 6'd9;
    tick(); tick();
    redirect = 1'b0;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_redir got=%b exp=0", dif.out_valid); end
    fill_random(0);
    load_prog();
    dif.out_ready = 1'b1;
    pulse_start();
    tick(); tick();
    n_cmp++; if (dif.out_valid !== 1'b1 || dif.out_pc !== '0) begin n_err++; $display("FAIL idle_pc got v=%b pc=%0d exp v=1 pc=0", dif.out_valid, dif.out_pc); end
    imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = ~mem_m[1];
    tick(); tick(); tick();
    imem_we = 1'b0;
    redirect = 1'b1; redirect_pc = 6'd1;
    tick();
    redirect = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      if (dif.out_valid) begin
        n_cmp++;
        if (dif.out_pc !== 6'd1 || dif.out_instr !== mem_m[1]) begin
          n_err++; $display("FAIL run_we got pc=%0d instr=%h exp pc=1 instr=%h", dif.out_pc, dif.out_instr, mem_m[1]);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL run_we_timeout got=%0d exp=1", got); end
  endtask

  task automatic test_random();
    int exp_pc;
    bit stopped;
    bit redir;
    logic [AW-1:0] tgt;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      fill_random(8);
      load_prog();
      pulse_start();
      exp_pc = 0;
      stopped = 0;
      for (int c = 0; c < 300; c++) begin
        dif.out_ready = ($urandom_range(3) != 0);
        redir = ($urandom_range(19) == 0);
        tgt = AW'($urandom);
        redirect = redir;
        redirect_pc = tgt;
        if (dif.out_valid && dif.out_ready) begin
          n_cmp++;
          if (stopped) begin
            n_err++; $display("FAIL rnd%0d_past_halt got pc=%0d exp no transfer", it, dif.out_pc);
          end else begin
            if (dif.out_pc !== AW'(exp_pc) || dif.out_instr !== mem_m[exp_pc]) begin
              n_err++;
              $display("FAIL rnd%0d got pc=%0d instr=%h exp pc=%0d instr=%h",
                       it, dif.out_pc, dif.out_instr, exp_pc, mem_m[exp_pc]);
            end
            if (mem_m[exp_pc][15:12] == HALT_OP) stopped = 1;
            exp_pc = (exp_pc + 1) % NW;
          end
        end
        if (redir) begin
          exp_pc = int'(tgt);
          stopped = 0;
        end
        tick();
      end
      redirect = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_backpressure();
    test_redirect();
    test_halt_redirect();
    test_wrap();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
